// File: rtl/conv_tap_sequencer.sv
// Convolution loop-nest sequencer: walks output pixels and kernel taps, issuing one MAC tap per handshake.
// Optional start-time config validation is built when CONV_SEQ_CFG_CHECK_EN is defined.
module conv_tap_sequencer #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        kernel_h,
    input  logic [3:0]        kernel_w,
    input  logic [7:0]        input_h,
    input  logic [7:0]        input_w,
    input  logic [3:0]        stride,
    input  logic [3:0]        padding,
    input  logic [7:0]        output_h,
    input  logic [7:0]        output_w,
    input  logic              pe_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    output logic              pad_zero,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic [ADDR_W-1:0] out_addr
);

    localparam int unsigned CW = 14;
    localparam int unsigned PW = 32;
    localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [3:0] kh;
        logic [3:0] kw;
        logic [7:0] h;
        logic [7:0] w;
        logic [3:0] s;
        logic [3:0] p;
        logic [7:0] oh;
        logic [7:0] ow;
    } cfg_t;

    state_t            state_q, state_d;
    cfg_t              cfg_q, cfg_d, cfg_in;
    logic [3:0]        kx_q, kx_d, ky_q, ky_d;
    logic [7:0]        ox_q, ox_d, oy_q, oy_d;
    logic              issued_q, issued_d;
    logic              final_q, final_d;
    logic [DW-1:0]     drain_q, drain_d;

    logic              busy_d, done_d, valid_d, first_d, last_d, pad_d;
    logic [ADDR_W-1:0] ifm_d, wgt_d, out_d;

    logic [CW-1:0]        iy_u, ix_u;
    logic signed [CW-1:0] iy, ix;
    logic                 pad_c, kx_end, ky_end, ox_end, oy_end, tap_last_c, tap_final_c;
    logic [ADDR_W-1:0]    ifm_c, wgt_c, out_c;

    assign cfg_in = cfg_t'({kernel_h, kernel_w, input_h, input_w, stride, padding, output_h, output_w});

    // Tap geometry for the counter position about to be issued
    assign iy_u = CW'(oy_q) * CW'(cfg_q.s) + CW'(ky_q);
    assign ix_u = CW'(ox_q) * CW'(cfg_q.s) + CW'(kx_q);
    assign iy   = $signed(iy_u) - $signed(CW'(cfg_q.p));
    assign ix   = $signed(ix_u) - $signed(CW'(cfg_q.p));

    assign pad_c = iy[CW-1] || (iy >= $signed(CW'(cfg_q.h))) ||
                   ix[CW-1] || (ix >= $signed(CW'(cfg_q.w)));

    assign ifm_c = pad_c ? '0 :
                   ADDR_W'(PW'($unsigned(iy)) * PW'(cfg_q.w) + PW'($unsigned(ix)));
    assign wgt_c = ADDR_W'(PW'(ky_q) * PW'(cfg_q.kw) + PW'(kx_q));
    assign out_c = ADDR_W'(PW'(oy_q) * PW'(cfg_q.ow) + PW'(ox_q));

    assign kx_end      = (kx_q == cfg_q.kw - 4'd1);
    assign ky_end      = (ky_q == cfg_q.kh - 4'd1);
    assign ox_end      = (ox_q == cfg_q.ow - 8'd1);
    assign oy_end      = (oy_q == cfg_q.oh - 8'd1);
    assign tap_last_c  = kx_end && ky_end;
    assign tap_final_c = tap_last_c && ox_end && oy_end;

`ifdef CONV_SEQ_CFG_CHECK_EN
    logic cfg_bad_c, err_q, err_d, cfg_err_d;

    assign cfg_bad_c = (kernel_h == 4'd0) || (kernel_w == 4'd0) || (input_h == 8'd0) ||
                       (input_w == 8'd0) || (stride == 4'd0) || (output_h == 8'd0) ||
                       (output_w == 8'd0) ||
                       (10'(kernel_h) > 10'(input_h) + 10'(padding) + 10'(padding)) ||
                       (10'(kernel_w) > 10'(input_w) + 10'(padding) + 10'(padding));
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        kx_d     = kx_q;
        ky_d     = ky_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        issued_d = issued_q;
        final_d  = final_q;
        drain_d  = drain_q;
        busy_d   = (state_q == S_RUN) || (state_q == S_DRAIN);
        done_d   = 1'b0;
        valid_d  = mac_valid;
        first_d  = mac_first;
        last_d   = mac_last;
        pad_d    = pad_zero;
        ifm_d    = ifm_addr;
        wgt_d    = wgt_addr;
        out_d    = out_addr;
`ifdef CONV_SEQ_CFG_CHECK_EN
        err_d     = err_q;
        cfg_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // done still high means the DONE cycle is visible; restart only after it
                if (start && !done) begin
                    cfg_d    = cfg_in;
                    kx_d     = '0;
                    ky_d     = '0;
                    ox_d     = '0;
                    oy_d     = '0;
                    issued_d = 1'b0;
                    final_d  = 1'b0;
                    drain_d  = '0;
`ifdef CONV_SEQ_CFG_CHECK_EN
                    err_d    = cfg_bad_c;
                    state_d  = cfg_bad_c ? S_DONE : S_RUN;
`else
                    state_d  = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (mac_valid && pe_ready && final_q) begin
                    valid_d = 1'b0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else if ((!mac_valid || pe_ready) && !issued_q) begin
                    valid_d  = 1'b1;
                    first_d  = (kx_q == 4'd0) && (ky_q == 4'd0);
                    last_d   = tap_last_c;
                    pad_d    = pad_c;
                    ifm_d    = ifm_c;
                    wgt_d    = wgt_c;
                    out_d    = out_c;
                    final_d  = tap_final_c;
                    issued_d = tap_final_c;
                    if (kx_end) begin
                        kx_d = '0;
                        if (ky_end) begin
                            ky_d = '0;
                            if (ox_end) begin
                                ox_d = '0;
                                oy_d = oy_end ? 8'd0 : oy_q + 8'd1;
                            end else begin
                                ox_d = ox_q + 8'd1;
                            end
                        end else begin
                            ky_d = ky_q + 4'd1;
                        end
                    end else begin
                        kx_d = kx_q + 4'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(DRAIN_CYC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
`ifdef CONV_SEQ_CFG_CHECK_EN
                cfg_err_d = err_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, shadow configuration, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cfg_q     <= '0;
            kx_q      <= '0;
            ky_q      <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            issued_q  <= 1'b0;
            final_q   <= 1'b0;
            drain_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mac_valid <= 1'b0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            pad_zero  <= 1'b0;
            ifm_addr  <= '0;
            wgt_addr  <= '0;
            out_addr  <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            kx_q      <= kx_d;
            ky_q      <= ky_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            issued_q  <= issued_d;
            final_q   <= final_d;
            drain_q   <= drain_d;
            busy      <= busy_d;
            done      <= done_d;
            mac_valid <= valid_d;
            mac_first <= first_d;
            mac_last  <= last_d;
            pad_zero  <= pad_d;
            ifm_addr  <= ifm_d;
            wgt_addr  <= wgt_d;
            out_addr  <= out_d;
        end
    end

`ifdef CONV_SEQ_CFG_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            err_q   <= err_d;
            cfg_err <= cfg_err_d;
        end
    end
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Self-checking bench for conv_tap_sequencer: loop-nest reference model, random configs and backpressure.
module tb_conv_tap_sequencer;

    localparam int unsigned AW    = 16;
    localparam int unsigned DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst_n, start, pe_ready;
    logic [3:0]    kernel_h, kernel_w, stride, padding;
    logic [7:0]    input_h, input_w, output_h, output_w;
    logic          busy, done, cfg_err, mac_valid, mac_first, mac_last, pad_zero;
    logic [AW-1:0] ifm_addr, wgt_addr, out_addr;

    conv_tap_sequencer #(.ADDR_W(AW), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .kernel_h(kernel_h), .kernel_w(kernel_w), .input_h(input_h), .input_w(input_w),
        .stride(stride), .padding(padding), .output_h(output_h), .output_w(output_w),
        .pe_ready(pe_ready), .busy(busy), .done(done), .cfg_err(cfg_err),
        .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last), .pad_zero(pad_zero),
        .ifm_addr(ifm_addr), .wgt_addr(wgt_addr), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ifm;
        logic [15:0] wgt;
        logic [15:0] oaddr;
        logic        pad;
        logic        first;
        logic        last;
    } tap_t;

    tap_t obs[$];
    tap_t expq[$];
    int   n_cmp, n_fail;
    int   lat_first, lat_done, stalls, hold_viol;
    bit   timed_out, err_seen, err_any, busy_first, valid_seen;

    function automatic tap_t cur_tap();
        tap_t t;
        t.ifm   = ifm_addr;
        t.wgt   = wgt_addr;
        t.oaddr = out_addr;
        t.pad   = pad_zero;
        t.first = mac_first;
        t.last  = mac_last;
        return t;
    endfunction

    task automatic set_cfg(input int kh, input int kw, input int h, input int w,
                           input int s, input int p, input int oh, input int ow);
        kernel_h = 4'(kh); kernel_w = 4'(kw); input_h  = 8'(h);  input_w  = 8'(w);
        stride   = 4'(s);  padding  = 4'(p);  output_h = 8'(oh); output_w = 8'(ow);
    endtask

    // Expected tap stream straight from the coordinate rules
    function automatic void build_model(input int kh, input int kw, input int h, input int w,
                                        input int s, input int p, input int oh, input int ow);
        tap_t t;
        int iy, ix;
        expq.delete();
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < kh; ky++)
                    for (int kx = 0; kx < kw; kx++) begin
                        iy      = oy * s + ky - p;
                        ix      = ox * s + kx - p;
                        t.pad   = (iy < 0) || (iy >= h) || (ix < 0) || (ix >= w);
                        t.ifm   = t.pad ? 16'd0 : 16'(iy * w + ix);
                        t.wgt   = 16'(ky * kw + kx);
                        t.oaddr = 16'(oy * ow + ox);
                        t.first = (kx == 0) && (ky == 0);
                        t.last  = (kx == kw - 1) && (ky == kh - 1);
                        expq.push_back(t);
                    end
    endfunction

    // Pulses start, drives pe_ready per mode (0 always, 1 random, 2 one 3-cycle drop) and records accepted taps.
    task automatic run_capture(input int mode, input int stall_at, input int poke_at,
                               input bit poke_done, input int budget);
        int   idx, drop_left;
        bit   dropped, prev_stall, got_done;
        tap_t prev, cur;
        obs.delete();
        stalls = 0; hold_viol = 0; lat_first = -1; lat_done = -1;
        timed_out = 0; err_seen = 0; err_any = 0; busy_first = 0; valid_seen = 0;
        drop_left = 0; dropped = 0; prev_stall = 0; got_done = 0;
        prev = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        while (idx < budget && !got_done) begin
            cur = cur_tap();
            err_any |= cfg_err;
            if (mac_valid) valid_seen = 1;
            if (mac_valid && lat_first < 0) begin
                lat_first  = idx;
                busy_first = busy;
            end
            if (prev_stall && (cur !== prev || !mac_valid)) hold_viol++;
            start = (idx == poke_at);
            if (idx == poke_at) begin
                kernel_w = 4'($urandom_range(1, 15));
                kernel_h = 4'($urandom_range(1, 15));
                output_w = 8'($urandom_range(1, 255));
                stride   = 4'($urandom_range(1, 15));
            end
            if (done) begin
                got_done = 1;
                lat_done = idx;
                err_seen = cfg_err;
            end else begin
                case (mode)
                    1: pe_ready = ($urandom_range(0, 3) != 0);
                    2: begin
                        if (mac_valid && !dropped && obs.size() == stall_at) begin
                            dropped   = 1;
                            drop_left = 3;
                        end
                        pe_ready = (drop_left == 0);
                        if (drop_left > 0) drop_left--;
                    end
                    default: pe_ready = 1'b1;
                endcase
                if (mac_valid && !pe_ready) stalls++;
                if (mac_valid && pe_ready) obs.push_back(cur);
                prev_stall = mac_valid && !pe_ready;
                prev = cur;
                @(negedge clk);
                idx++;
            end
        end
        if (!got_done) timed_out = 1;
        pe_ready = 1'b1;
        start = poke_done && got_done;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({busy, done, cfg_err, mac_valid, mac_first, mac_last, pad_zero} !== 7'b0 ||
            ifm_addr !== 16'd0 || wgt_addr !== 16'd0 || out_addr !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got flags=%b ifm=%h wgt=%h out=%h want all 0",
                     {busy, done, cfg_err, mac_valid, mac_first, mac_last, pad_zero},
                     ifm_addr, wgt_addr, out_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || mac_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", busy, mac_valid);
        end
    endtask

    task automatic test_basic();
        int exp_ifm[4] = '{0, 1, 3, 4};
        int k;
        set_cfg(2, 2, 3, 3, 1, 0, 2, 2);
        build_model(2, 2, 3, 3, 1, 0, 2, 2);
        run_capture(0, -1, -1, 0, 200);
        n_cmp++;
        if (timed_out || obs.size() != 16) begin
            n_fail++;
            $display("FAIL basic_count: got %0d taps timeout=%0d want 16", obs.size(), timed_out);
        end
        n_cmp++;
        if (lat_first != 1 || busy_first !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_startup: got lat=%0d busy=%b want 1 1", lat_first, busy_first);
        end
        n_cmp++;
        if (lat_done - lat_first != 16 + DRAIN + 1 || err_seen) begin
            n_fail++;
            $display("FAIL basic_runtime: got %0d err=%0d want %0d", lat_done - lat_first, err_seen, 16 + DRAIN + 1);
        end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i].ifm != 16'(exp_ifm[i]) || obs[i].wgt != 16'(i)) begin
                n_fail++;
                $display("FAIL basic_window0[%0d]: got ifm=%0d wgt=%0d want %0d %0d", i, obs[i].ifm, obs[i].wgt, exp_ifm[i], i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            k = 4 * i + 3;
            if (k < obs.size()) begin
                n_cmp++;
                if (!obs[k].last || obs[k].oaddr != 16'(i)) begin
                    n_fail++;
                    $display("FAIL basic_out[%0d]: got last=%b out=%0d want 1 %0d", i, obs[k].last, obs[k].oaddr, i);
                end
            end
        end
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== expq[i]) begin
                n_fail++;
                $display("FAIL basic_tap[%0d]: got %h want %h", i, obs[i], expq[i]);
            end
        end
    endtask

    task automatic test_padding();
        set_cfg(3, 3, 4, 4, 1, 1, 4, 4);
        build_model(3, 3, 4, 4, 1, 1, 4, 4);
        run_capture(0, -1, -1, 0, 400);
        n_cmp++;
        if (timed_out || obs.size() != 144 || lat_done - lat_first != 144 + DRAIN + 1) begin
            n_fail++;
            $display("FAIL pad_count: got %0d taps runtime=%0d want 144 %0d", obs.size(), lat_done - lat_first, 144 + DRAIN + 1);
        end
        if (obs.size() == 144) begin
            n_cmp++;
            if (obs[0].pad !== 1'b1 || obs[0].ifm != 16'd0 || obs[4].pad !== 1'b0 ||
                obs[4].ifm != 16'd0 || obs[143].pad !== 1'b1) begin
                n_fail++;
                $display("FAIL pad_points: got t0=%b/%0d t4=%b/%0d t143=%b want 1/0 0/0 1",
                         obs[0].pad, obs[0].ifm, obs[4].pad, obs[4].ifm, obs[143].pad);
            end
        end
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== expq[i]) begin
                n_fail++;
                $display("FAIL pad_tap[%0d]: got %h want %h", i, obs[i], expq[i]);
            end
        end
    endtask

    task automatic test_stride();
        set_cfg(3, 3, 5, 5, 2, 0, 2, 2);
        build_model(3, 3, 5, 5, 2, 0, 2, 2);
        run_capture(0, -1, -1, 0, 200);
        n_cmp++;
        if (timed_out || obs.size() != 36) begin
            n_fail++;
            $display("FAIL stride_count: got %0d taps want 36", obs.size());
        end
        if (obs.size() == 36) begin
            n_cmp++;
            if (obs[9].ifm != 16'd2 || obs[18].ifm != 16'd10 || !obs[9].first || !obs[18].first) begin
                n_fail++;
                $display("FAIL stride_first: got out1=%0d out2=%0d want 2 10", obs[9].ifm, obs[18].ifm);
            end
        end
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== expq[i]) begin
                n_fail++;
                $display("FAIL stride_tap[%0d]: got %h want %h", i, obs[i], expq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        set_cfg(2, 2, 3, 3, 1, 0, 2, 2);
        build_model(2, 2, 3, 3, 1, 0, 2, 2);
        run_capture(2, 5, -1, 0, 200);
        n_cmp++;
        if (timed_out || stalls != 3 || hold_viol != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got stalls=%0d hold_viol=%0d want 3 0", stalls, hold_viol);
        end
        n_cmp++;
        if (lat_done - lat_first != 16 + 3 + DRAIN + 1) begin
            n_fail++;
            $display("FAIL bp_runtime: got %0d want %0d", lat_done - lat_first, 16 + 3 + DRAIN + 1);
        end
        n_cmp++;
        if (obs.size() != 16) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want 16", obs.size());
        end
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== expq[i]) begin
                n_fail++;
                $display("FAIL bp_tap[%0d]: got %h want %h", i, obs[i], expq[i]);
            end
        end
    endtask

    task automatic test_random();
        int kh, kw, h, w, s, p, oh, ow, taps;
        for (int r = 0; r < 6; r++) begin
            kh = $urandom_range(1, 3); kw = $urandom_range(1, 3);
            p  = $urandom_range(0, 1); s  = $urandom_range(1, 2);
            h  = $urandom_range(kh, 7); w  = $urandom_range(kw, 7);
            oh = (h + 2 * p - kh) / s + 1;
            ow = (w + 2 * p - kw) / s + 1;
            taps = oh * ow * kh * kw;
            set_cfg(kh, kw, h, w, s, p, oh, ow);
            build_model(kh, kw, h, w, s, p, oh, ow);
            run_capture(1, -1, -1, 0, 4 * taps + 50);
            n_cmp++;
            if (timed_out || obs.size() != taps || hold_viol != 0) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d taps hold_viol=%0d want %0d 0", r, obs.size(), hold_viol, taps);
            end
            n_cmp++;
            if (lat_done - lat_first != taps + stalls + DRAIN + 1) begin
                n_fail++;
                $display("FAIL rand%0d_runtime: got %0d want %0d", r, lat_done - lat_first, taps + stalls + DRAIN + 1);
            end
            for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
                n_cmp++;
                if (obs[i] !== expq[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_tap[%0d]: got %h want %h", r, i, obs[i], expq[i]);
                end
            end
        end
    endtask

    task automatic test_control();
        // start plus config changes mid-run, then start on the done cycle
        set_cfg(2, 2, 3, 3, 1, 0, 2, 2);
        build_model(2, 2, 3, 3, 1, 0, 2, 2);
        run_capture(0, -1, 6, 1, 200);
        n_cmp++;
        if (timed_out || obs.size() != 16 || lat_done - lat_first != 16 + DRAIN + 1) begin
            n_fail++;
            $display("FAIL ctl_ignore_run: got %0d taps runtime=%0d want 16 %0d", obs.size(), lat_done - lat_first, 16 + DRAIN + 1);
        end
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== expq[i]) begin
                n_fail++;
                $display("FAIL ctl_tap[%0d]: got %h want %h", i, obs[i], expq[i]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (busy !== 1'b0 || mac_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ctl_ignore_done[%0d]: got busy=%b valid=%b want 0 0", c, busy, mac_valid);
            end
            @(negedge clk);
        end
        // asynchronous reset in the middle of a run
        set_cfg(2, 2, 3, 3, 1, 0, 2, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (mac_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ctl_midrun: got valid=%b busy=%b want 1 1", mac_valid, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, cfg_err, mac_valid, mac_first, mac_last, pad_zero} !== 7'b0 ||
            ifm_addr !== 16'd0 || wgt_addr !== 16'd0 || out_addr !== 16'd0) begin
            n_fail++;
            $display("FAIL ctl_async_reset: got flags=%b ifm=%h wgt=%h out=%h want all 0",
                     {busy, done, cfg_err, mac_valid, mac_first, mac_last, pad_zero},
                     ifm_addr, wgt_addr, out_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_capture(0, -1, -1, 0, 200);
        n_cmp++;
        if (timed_out || obs.size() != 16 || lat_first != 1) begin
            n_fail++;
            $display("FAIL ctl_restart: got %0d taps lat=%0d want 16 1", obs.size(), lat_first);
        end
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== expq[i]) begin
                n_fail++;
                $display("FAIL ctl_restart_tap[%0d]: got %h want %h", i, obs[i], expq[i]);
            end
        end
    endtask

    task automatic test_cfg_check();
`ifdef CONV_SEQ_CFG_CHECK_EN
        set_cfg(2, 0, 3, 3, 1, 0, 2, 2);
        run_capture(0, -1, -1, 0, 50);
        n_cmp++;
        if (timed_out || !err_seen || valid_seen || obs.size() != 0 || lat_done != 1) begin
            n_fail++;
            $display("FAIL cfg_kw0: got err=%0d valid=%0d taps=%0d lat=%0d want 1 0 0 1",
                     err_seen, valid_seen, obs.size(), lat_done);
        end
        set_cfg(5, 1, 3, 3, 1, 0, 1, 3);
        run_capture(0, -1, -1, 0, 50);
        n_cmp++;
        if (timed_out || !err_seen || valid_seen) begin
            n_fail++;
            $display("FAIL cfg_kh_big: got err=%0d valid=%0d want 1 0", err_seen, valid_seen);
        end
`endif
        set_cfg(2, 2, 3, 3, 1, 0, 2, 2);
        run_capture(0, -1, -1, 0, 200);
        n_cmp++;
        if (timed_out || err_seen || err_any || obs.size() != 16) begin
            n_fail++;
            $display("FAIL cfg_valid: got err=%0d err_any=%0d taps=%0d want 0 0 16", err_seen, err_any, obs.size());
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; pe_ready = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_padding();
        test_stride();
        test_backpressure();
        test_random();
        test_control();
        test_cfg_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_tap_sequencer.md
# conv_tap_sequencer

Loop-nest sequencer for the PE convolution datapath. On a `start` pulse from the configuration register block it latches the kernel, input, stride, padding and output parameters. It then walks every output pixel and every kernel tap, issuing one MAC tap per accepted cycle with input-feature-map address, weight address, zero-padding flag and accumulate framing. When the PE pipeline has drained it raises a one-cycle `done`, which feeds the status register.

## Interface
- `ADDR_W`, 16, width of `ifm_addr`, `wgt_addr`, `out_addr`
- `DRAIN_CYC`, 2, cycles waited after the final tap before `done` (PE pipeline depth)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle start pulse; ignored unless idle
- `kernel_h`, `kernel_w`  in  4 each  kernel dimensions KH, KW
- `input_h`, `input_w`  in  8 each  input dimensions H, W
- `stride`, `padding`  in  4 each  S, P
- `output_h`, `output_w`  in  8 each  output dimensions OH, OW (software-computed, used as loop bounds)
- `pe_ready`  in  1  PE accepts the current tap
- `busy`  out  1  high from `start` acceptance until `done`
- `done`  out  1  one-cycle completion pulse
- `cfg_err`  out  1  qualifies `done`: the run was rejected
- `mac_valid`  out  1  tap valid
- `mac_first`  out  1  first tap of a window (clear accumulator)
- `mac_last`  out  1  last tap of a window (write result)
- `pad_zero`  out  1  tap lies in the padding region; PE uses operand 0
- `ifm_addr`  out  ADDR_W  iy*W + ix; 0 when `pad_zero`
- `wgt_addr`  out  ADDR_W  ky*KW + kx
- `out_addr`  out  ADDR_W  oy*OW + ox; meaningful when `mac_valid & mac_last`

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- **IDLE:** `busy=0`. On `start`, latch all config inputs into shadow registers, zero the counters, and go to RUN. Config input changes after latching have no effect.
- **RUN:** the loop order is `kx` (innermost), `ky`, `ox`, `oy`.
  - Each counter wraps at bound−1 (KW, KH, OW, OH) and carries into the next counter.
  - A tap advances only on the handshake `mac_valid & pe_ready`.
- **Coordinates:** iy = oy*S + ky − P and ix = ox*S + kx − P, both computed signed at 10 bits minimum.
  - `pad_zero=1` if iy<0, iy≥H, ix<0 or ix≥W.
  - Address arithmetic is truncated to ADDR_W.
- **Tap framing:**
  - `mac_first = (kx==0 && ky==0)`.
  - `mac_last = (kx==KW−1 && ky==KH−1)`.
  - For a 1x1 kernel, both flags are high on every tap.
- When the final tap (oy=OH−1, ox=OW−1, last tap) is accepted, go to DRAIN with `mac_valid=0`.
- **DRAIN:** count DRAIN_CYC cycles, then go to DONE.
- **DONE:** `done=1` for one cycle, `busy` falls in the same edge, then go to IDLE.
- A `start` in any state other than IDLE is ignored.
- Async reset at any time: return to IDLE immediately; all outputs 0; an in-flight run is abandoned.

## Timing
- Reset values: every output is 0.
- All outputs are registered.
- **Startup:** `start` sampled at edge N gives `busy=1` and the first tap (`mac_valid=1`) after edge N+1.
- **Stall:** while `mac_valid=1 && pe_ready=0`, every tap output holds its value. `mac_valid` never drops without a handshake.
- **Throughput:** one tap per cycle while `pe_ready=1`.
- **Total runtime** from the first tap to `done`, with no stalls: OH*OW*KH*KW tap cycles + DRAIN_CYC + 1.
- **Back-to-back runs:** a `start` coinciding with the `done` cycle is ignored. The earliest accepted restart is the cycle after `done`.

## Configuration
- Macro `CONV_SEQ_CFG_CHECK_EN`.
- **Defined:** on `start`, if any of KH, KW, H, W, S, OH, OW is 0, or KH > H+2P, or KW > W+2P, go IDLE → DONE directly. `done=1` and `cfg_err=1` for one cycle after 2 edges; no taps are issued.
- **Undefined:** no check logic is built, and `cfg_err` is tied 0. Zero-valued configs are unsupported and must be prevented by software.

## Test plan
- **Basic run:** H=W=3, K=2x2, S=1, P=0, OH=OW=2, `pe_ready=1`.
  - Expect 16 taps. The first window has ifm_addr 0,1,3,4 and wgt_addr 0,1,2,3.
  - `out_addr` is 0,1,2,3 on the `mac_last` taps.
  - `done` arrives 16+2+1 cycles after the first tap.
- **Padding:** H=W=4, K=3x3, S=1, P=1, OH=OW=4.
  - Output 0, tap (0,0): `pad_zero=1`, `ifm_addr=0`.
  - Output 0, tap (1,1): `pad_zero=0`, `ifm_addr=0`.
  - Output 15, tap (2,2): `pad_zero=1`.
  - Total 144 taps.
- **Stride:** H=W=5, K=3x3, S=2, P=0, OH=OW=2.
  - The first tap of output 1 has `ifm_addr=2`.
  - The first tap of output 2 has `ifm_addr=10`.
- **Backpressure:** drop `pe_ready` for 3 cycles mid-window. All tap outputs hold, no tap is skipped or repeated, and `done` is delayed by exactly 3 cycles.
- **Control events:**
  - `start` during RUN and during DONE is ignored.
  - Async reset mid-RUN zeroes all outputs immediately.
  - A subsequent `start` runs cleanly from tap 0.
- **Config check** (macro defined): KW=0 gives `done` and `cfg_err` together, with `mac_valid` never asserted. With the macro undefined, `cfg_err` stays 0.
